// File: rtl/mod_mul_pipe_pkg.sv
// Shared constants for the modular twiddle multiplier.
//   D_WIDTH_DEF   : default data/modulus width
//   LATENCY       : fixed pipeline depth of mod_mul_pipe
//   N_GOLDILOCKS  : example modulus 2^64 - 2^32 + 1
//   MU_GOLDILOCKS : matching Barrett constant floor(2^128 / N_GOLDILOCKS)
package mod_mul_pipe_pkg;

    localparam int D_WIDTH_DEF = 64;
    localparam int LATENCY     = 4;

    localparam logic [63:0] N_GOLDILOCKS  = 64'hFFFF_FFFF_0000_0001;
    localparam logic [64:0] MU_GOLDILOCKS = 65'h1_0000_0000_FFFF_FFFF;

endpackage

// File: rtl/mod_reduce_final.sv
// Final correction of a Barrett remainder known to lie in [0, 3N).
// Purely combinational; subtracts 2N or N as needed.
//   r_i : partially reduced value, W+2 bits, 0 <= r_i < 3N
//   n_i : modulus, W bits
//   r_o : fully reduced value, 0 <= r_o < N
module mod_reduce_final
    import mod_mul_pipe_pkg::*;
#(
    parameter int W = D_WIDTH_DEF
) (
    input  logic [W+1:0] r_i,
    input  logic [W-1:0] n_i,
    output logic [W-1:0] r_o
);

    logic [W+1:0] n1;
    logic [W+1:0] n2;

    assign n1 = {2'b00, n_i};
    assign n2 = {1'b0, n_i, 1'b0};

    always_comb begin
        r_o = r_i[W-1:0];
        if (r_i >= n2) begin
            r_o = W'(r_i - n2);
        end else if (r_i >= n1) begin
            r_o = W'(r_i - n1);
        end
    end

endmodule

// File: rtl/mod_mul_pipe.sv
// Pipelined modular multiplier R1_out = (R1_in * W_in) mod N_in using Barrett
// reduction, with R0_in delayed alongside so butterfly operands stay aligned.
// Four register stages, one operation per cycle, global stall freezes all.
//   clk, rst          : clock, asynchronous active-high reset
//   valid_in, stall   : operand strobe (ignored while stalled), pipeline freeze
//   R0_in, R1_in, W_in: butterfly top operand, bottom operand, twiddle
//   N_in, MU_in       : modulus (MSB set) and Barrett constant, quasi-static
//   valid_out, R0_out, R1_out : aligned results
//   busy              : any stage holds a valid operation
module mod_mul_pipe
    import mod_mul_pipe_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    input  logic               stall,
    input  logic [D_WIDTH-1:0] R0_in,
    input  logic [D_WIDTH-1:0] R1_in,
    input  logic [D_WIDTH-1:0] W_in,
    input  logic [D_WIDTH-1:0] N_in,
    input  logic [D_WIDTH:0]   MU_in,
    output logic               valid_out,
    output logic [D_WIDTH-1:0] R0_out,
    output logic [D_WIDTH-1:0] R1_out,
    output logic               busy
);

    localparam int PW = 2 * D_WIDTH;   // full product
    localparam int QW = D_WIDTH + 1;   // quotient estimate / Barrett operands
    localparam int RW = D_WIDTH + 2;   // remainder arithmetic, 0 <= r < 3N

    logic [LATENCY-1:0] v_q, v_d;
    logic [D_WIDTH-1:0] r0_q [LATENCY];
    logic [D_WIDTH-1:0] r0_d [LATENCY];

    logic [PW-1:0]      s1_p_q,   s1_p_d;
    logic [QW-1:0]      s2_q_q,   s2_q_d;
    logic [RW-1:0]      s2_plo_q, s2_plo_d;
    logic [RW-1:0]      s3_r_q,   s3_r_d;
    logic [D_WIDTH-1:0] s4_r1_q,  s4_r1_d;

    logic [QW-1:0]      p_hi;
    logic [RW-1:0]      qn_lo;

    // Only the low RW bits of P and q*N matter: the true difference is
    // below 3N < 2^RW, so wrap-around in RW bits gives the exact remainder.
    assign p_hi  = s1_p_q[PW-1:D_WIDTH-1];
    assign qn_lo = RW'(s2_q_q) * RW'(N_in);

    mod_reduce_final #(
        .W (D_WIDTH)
    ) u_reduce (
        .r_i (s3_r_q),
        .n_i (N_in),
        .r_o (s4_r1_d)
    );

    always_comb begin
        v_d      = {v_q[LATENCY-2:0], valid_in};
        r0_d[0]  = R0_in;
        for (int i = 1; i < LATENCY; i++) begin
            r0_d[i] = r0_q[i-1];
        end
        s1_p_d   = PW'(R1_in) * PW'(W_in);
        s2_q_d   = QW'(((2*QW)'(p_hi) * (2*QW)'(MU_in)) >> QW);
        s2_plo_d = s1_p_q[RW-1:0];
        s3_r_d   = s2_plo_q - qn_lo;
    end

    // Data registers advance even for bubbles; only the valid bits qualify them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q      <= '0;
            s1_p_q   <= '0;
            s2_q_q   <= '0;
            s2_plo_q <= '0;
            s3_r_q   <= '0;
            s4_r1_q  <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r0_q[i] <= '0;
            end
        end else if (!stall) begin
            v_q      <= v_d;
            s1_p_q   <= s1_p_d;
            s2_q_q   <= s2_q_d;
            s2_plo_q <= s2_plo_d;
            s3_r_q   <= s3_r_d;
            s4_r1_q  <= s4_r1_d;
            for (int i = 0; i < LATENCY; i++) begin
                r0_q[i] <= r0_d[i];
            end
        end
    end

    assign valid_out = v_q[LATENCY-1];
    assign R0_out    = r0_q[LATENCY-1];
    assign R1_out    = s4_r1_q;
    assign busy      = |v_q;

endmodule
